audio_pdm_demod: RTL and testbench

Stereo PDM-to-PCM demodulator (decimator) for the audio path.
- Recovers two unsigned PCM channels from one interleaved 1-bit PDM stream `sdi`, clocked by a separate bit clock `ock`.
- Left bit is carried on the `ock` rising edge, right bit on the `ock` falling edge.
- Runs entirely in the `clk` domain: it synchronizes `ock`/`sdi`, counts ones over a fixed boxcar window per channel, and publishes a full-scale-normalized sample per window.
- Sits after the audio PDM modulator / PDM microphone input, before PCM processing.

---
 rtl/audio_pdm_demod.sv | 154 +++++++++++++++
 tb/tb_audio_pdm_demod.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/audio_pdm_demod.sv
// -----------------------------------------------------------------------------
// audio_pdm_demod
// Stereo PDM-to-PCM boxcar decimator.
//
// One interleaved 1-bit PDM stream (sdi) carries two channels: the left bit is
// valid at the rising edge of the PDM bit clock (ock), and the right bit is
// valid at the falling edge. Both ock and sdi are asynchronous to clk. They
// are synchronized into clk, and each channel counts ones over a window of
// 2^DEC_LOG2 bits. At the end of each window the channel publishes a
// full-scale-normalized unsigned sample.
//
// Parameters:
//   DW        PCM output width per channel (default 32)
//   DEC_LOG2  log2 of the window length in bits per channel (default 6 -> 64)
//             Must satisfy 1 <= DEC_LOG2 < DW.
//
// Ports:
//   clk     in   system clock, rising edge
//   rstn    in   asynchronous active-low reset
//   sdi     in   PDM serial data (async)
//   ock     in   PDM bit clock (async), each half-period >= 3 clk periods
//   dout_l  out  left PCM sample, registered
//   dout_r  out  right PCM sample, registered
//   vld_l   out  one-cycle pulse when dout_l updates  (AUDIO_PDM_DEMOD_VALID_EN)
//   vld_r   out  one-cycle pulse when dout_r updates  (AUDIO_PDM_DEMOD_VALID_EN)
//
// Optional feature macro: AUDIO_PDM_DEMOD_VALID_EN adds vld_l/vld_r.
// vld_x has no ready: it is a strobe that is high for exactly the one clk
// cycle in which the new dout_x value first appears. The consumer must
// capture the sample in that cycle or read the held dout_x later.
// -----------------------------------------------------------------------------
module audio_pdm_demod #(
    parameter int DW       = 32,
    parameter int DEC_LOG2 = 6
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          sdi,
    input  logic          ock,
    output logic [DW-1:0] dout_l,
    output logic [DW-1:0] dout_r
`ifdef AUDIO_PDM_DEMOD_VALID_EN
    ,
    output logic          vld_l,
    output logic          vld_r
`endif
);

    // A count equal to this means every bit in the window was a one.
    localparam logic [DEC_LOG2:0] FULL = {1'b1, {DEC_LOG2{1'b0}}};

    // Synchronizers plus one delay stage for edge detection and bit alignment.
    logic ock_s1, ock_s, ock_d;
    logic sdi_s1, sdi_s, sdi_d;
    logic rise, fall;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ock_s1 <= 1'b0;
            ock_s  <= 1'b0;
            ock_d  <= 1'b0;
            sdi_s1 <= 1'b0;
            sdi_s  <= 1'b0;
            sdi_d  <= 1'b0;
        end else begin
            ock_s1 <= ock;
            ock_s  <= ock_s1;
            ock_d  <= ock_s;
            sdi_s1 <= sdi;
            sdi_s  <= sdi_s1;
            sdi_d  <= sdi_s;
        end
    end

    // sdi_d lags the edge-detect stage by one flop. The bit used at an edge
    // is therefore the sdi level that was present just before that ock edge.
    assign rise = ock_s & ~ock_d;
    assign fall = ~ock_s & ock_d;

    // Normalize a window count to full scale. A full window saturates to
    // all-ones, so it does not wrap to zero.
    function automatic logic [DW-1:0] scale(input logic [DEC_LOG2:0] c);
        logic [DW-1:0] w;
        w = '0;
        w[DEC_LOG2:0] = c;
        if (c == FULL) return {DW{1'b1}};
        return w << (DW - DEC_LOG2);
    endfunction

    // The left and right channels are independent, identical accumulators.
    logic [DEC_LOG2-1:0] nb_l, nb_r;
    logic [DEC_LOG2:0]   ones_l, ones_r;
    logic [DEC_LOG2:0]   c_l, c_r;

    assign c_l = ones_l + {{DEC_LOG2{1'b0}}, sdi_d};
    assign c_r = ones_r + {{DEC_LOG2{1'b0}}, sdi_d};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            nb_l   <= '0;
            ones_l <= '0;
            dout_l <= '0;
`ifdef AUDIO_PDM_DEMOD_VALID_EN
            vld_l  <= 1'b0;
`endif
        end else begin
`ifdef AUDIO_PDM_DEMOD_VALID_EN
            vld_l <= 1'b0;
`endif
            if (rise) begin
                if (nb_l != '1) begin
                    ones_l <= c_l;
                    nb_l   <= nb_l + DEC_LOG2'(1);
                end else begin
                    dout_l <= scale(c_l);
                    ones_l <= '0;
                    nb_l   <= '0;
`ifdef AUDIO_PDM_DEMOD_VALID_EN
                    vld_l  <= 1'b1;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            nb_r   <= '0;
            ones_r <= '0;
            dout_r <= '0;
`ifdef AUDIO_PDM_DEMOD_VALID_EN
            vld_r  <= 1'b0;
`endif
        end else begin
`ifdef AUDIO_PDM_DEMOD_VALID_EN
            vld_r <= 1'b0;
`endif
            if (fall) begin
                if (nb_r != '1) begin
                    ones_r <= c_r;
                    nb_r   <= nb_r + DEC_LOG2'(1);
                end else begin
                    dout_r <= scale(c_r);
                    ones_r <= '0;
                    nb_r   <= '0;
`ifdef AUDIO_PDM_DEMOD_VALID_EN
                    vld_r  <= 1'b1;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_audio_pdm_demod.sv
`timescale 1ns/100ps
module tb_audio_pdm_demod;

    localparam int DW       = 32;
    localparam int DEC_LOG2 = 6;
    localparam int WIN      = 1 << DEC_LOG2;

    logic          clk;
    logic          rstn;
    logic          sdi;
    logic          ock;
    logic [DW-1:0] dout_l;
    logic [DW-1:0] dout_r;
`ifdef AUDIO_PDM_DEMOD_VALID_EN
    logic          vld_l;
    logic          vld_r;
`endif

    int errors = 0;
    int checks = 0;

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    audio_pdm_demod #(.DW(DW), .DEC_LOG2(DEC_LOG2)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .sdi    (sdi),
        .ock    (ock),
        .dout_l (dout_l),
        .dout_r (dout_r)
`ifdef AUDIO_PDM_DEMOD_VALID_EN
        ,
        .vld_l  (vld_l),
        .vld_r  (vld_r)
`endif
    );

    // Reference model: collect each channel's bits in a window queue. When a
    // window fills, the published sample is density * 2^DW, saturated at full.
    bit            win_l_q[$];
    bit            win_r_q[$];
    logic [DW-1:0] exp_l = '0;
    logic [DW-1:0] exp_r = '0;
    int            windows_l = 0;
    int            windows_r = 0;

    function automatic logic [DW-1:0] model_sample(input int ones);
        longint v;
        v = (longint'(ones) << DW) / WIN;          // density * 2^DW
        if (v >= (longint'(1) << DW)) v = (longint'(1) << DW) - 1;
        return v[DW-1:0];
    endfunction

    task automatic model_push(input bit bl, input bit br);
        int s;
        win_l_q.push_back(bl);
        win_r_q.push_back(br);
        if (win_l_q.size() == WIN) begin
            s = 0;
            foreach (win_l_q[i]) s += int'(win_l_q[i]);
            exp_l = model_sample(s);
            win_l_q.delete();
            windows_l++;
        end
        if (win_r_q.size() == WIN) begin
            s = 0;
            foreach (win_r_q[i]) s += int'(win_r_q[i]);
            exp_r = model_sample(s);
            win_r_q.delete();
            windows_r++;
        end
    endtask

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Driver: one full ock period of 8 clk cycles, driven on falling clk edges.
    // The left bit is set 1 clk before the rise, and the right bit 2 clk
    // before the fall. When the task returns, both edges have been processed.
    task automatic pdm_period(input bit bl, input bit br);
        sdi = bl;
        @(negedge clk);
        ock = 1'b1;
        repeat (2) @(negedge clk);
        sdi = br;
        repeat (2) @(negedge clk);
        ock = 1'b0;
        repeat (3) @(negedge clk);
        model_push(bl, br);
        check("dout_l", dout_l, exp_l);
        check("dout_r", dout_r, exp_r);
    endtask

    // Pulse counters for the optional valid strobes.
`ifdef AUDIO_PDM_DEMOD_VALID_EN
    int vld_cnt_l = 0;
    int vld_cnt_r = 0;
    always @(posedge clk) begin
        if (vld_l === 1'b1) vld_cnt_l++;
        if (vld_r === 1'b1) vld_cnt_r++;
    end
`endif

    initial begin
        int p;
        logic [DW-1:0] hold_l, hold_r;
        rstn = 1'b0;
        sdi  = 1'b0;
        ock  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_dout_l", dout_l, '0);
        check("reset_dout_r", dout_r, '0);
        rstn = 1'b1;
        @(negedge clk);

        // All ones: both outputs stay 0 until the 64th edge, then saturate.
        for (int i = 0; i < WIN; i++) pdm_period(1'b1, 1'b1);
        check("all_ones_l", dout_l, 32'hFFFF_FFFF);
        check("all_ones_r", dout_r, 32'hFFFF_FFFF);

        // All zeros over two windows.
        for (int i = 0; i < 2 * WIN; i++) pdm_period(1'b0, 1'b0);
        check("all_zeros_l", dout_l, 32'h0);

        // Left always 1, right always 0.
        for (int i = 0; i < 2 * WIN; i++) pdm_period(1'b1, 1'b0);
        check("split_l", dout_l, 32'hFFFF_FFFF);
        check("split_r", dout_r, 32'h0);

        // Left pattern 1,0,0,0 and right pattern 1,0.
        for (int i = 0; i < WIN; i++) pdm_period((i % 4) == 0, (i % 2) == 0);
        check("quarter_l", dout_l, 32'h4000_0000);
        check("half_r", dout_r, 32'h8000_0000);

        // ock stopped: outputs hold.
        hold_l = exp_l;
        hold_r = exp_r;
        repeat (40) @(negedge clk);
        check("stopped_l", dout_l, hold_l);
        check("stopped_r", dout_r, hold_r);

        // Random density per window.
        for (int w = 0; w < 6; w++) begin
            p = $urandom_range(0, 100);
            for (int i = 0; i < WIN; i++)
                pdm_period($urandom_range(0, 99) < p, $urandom_range(0, 99) < 100 - p);
        end

        // Reset mid-window after 30 left bits of ones.
        for (int i = 0; i < 30; i++) pdm_period(1'b1, 1'b1);
        #2 rstn = 1'b0;
        #1;
        check("async_rst_l", dout_l, '0);
        check("async_rst_r", dout_r, '0);
        win_l_q.delete();
        win_r_q.delete();
        exp_l = '0;
        exp_r = '0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        for (int i = 0; i < WIN; i++) pdm_period(1'b1, 1'b1);
        check("post_rst_l", dout_l, 32'hFFFF_FFFF);

`ifdef AUDIO_PDM_DEMOD_VALID_EN
        repeat (4) @(negedge clk);
        check("vld_count_l", 32'(vld_cnt_l), 32'(windows_l));
        check("vld_count_r", 32'(vld_cnt_r), 32'(windows_r));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #2000000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
